ddr3_emif_arbiter: RTL and testbench
====================================

Name: ddr3_emif_arbiter

Overview:
- Shares the single DDR3 EMIF Avalon-MM port between two masters.
  - Master 0: pattern loader (writes pattern data, reads back).
  - Master 1: pattern fetch/send engine (reads header and body, may write status).
- Round-robin grant, locked for the full length of a write burst.
- Tracks outstanding read bursts so each returned beat is routed to the master that issued it.
- Sits between the masters and the EMIF controller, entirely in the ddr3_emif_clk domain.

Parameters:
- ADDR_W, 22, EMIF word address width.
- DATA_W, 256, data width.
- BE_W, 32, byte-enable width (DATA_W/8).
- BURST_W, 5, burstcount width.
- TRK_DEPTH, 8, maximum outstanding read bursts (power of 2).

Ports:
- ddr3_emif_clk  in  1  sole clock.
- ddr3_emif_rst  in  1  synchronous reset, active-high.
- mN_read, mN_write  in  1  request from master N (N=0,1).
- mN_addr  in  ADDR_W  address.
- mN_burst_count  in  BURST_W  burst length; 0 is treated as 1.
- mN_write_data  in  DATA_W  write data.
- mN_byte_enable  in  BE_W  byte enables.
- mN_waitrequest  out  1  master N must hold command/beat while high.
- mN_read_data  out  DATA_W  returned read data.
- mN_rddata_valid  out  1  read beat valid for master N.
- ddr3_emif_ready  in  1  EMIF accepts the command/beat this cycle.
- ddr3_emif_read, ddr3_emif_write  out  1  forwarded command.
- ddr3_emif_addr  out  ADDR_W  forwarded address.
- ddr3_emif_burst_count  out  BURST_W  forwarded burst length.
- ddr3_emif_write_data  out  DATA_W  forwarded write data.
- ddr3_emif_byte_enable  out  BE_W  forwarded byte enables.
- ddr3_emif_read_data  in  DATA_W  read data from EMIF.
- ddr3_emif_rddata_valid  in  1  read beat valid from EMIF.
- rsp_err  out  1  sticky: rddata_valid seen with no outstanding read burst.

Behaviour:
- Reset (synchronous, dominant over all events):
  - State ARB, last_grant=1, tracker emptied.
  - All emif_read/emif_write=0, mN_waitrequest=1, mN_rddata_valid=0, rsp_err=0.
  - Read beats still in flight at reset are discarded; the first such beat sets rsp_err.
- FSM states: ARB, GNT_RD, GNT_WR.
- ARB:
  - A master is eligible if mN_write, or if mN_read && !trk_full.
  - Grant the eligible master that is not last_grant; otherwise the only eligible one.
  - Register grant, last_grant and the burst length (0 is treated as 1).
  - Next state: GNT_WR if a write was granted, GNT_RD if a read was granted, ARB if none eligible.
  - All waitrequests stay 1 in ARB.
  - Latency: a request at edge n is driven to the EMIF from cycle n+1.
- GNT_RD:
  - EMIF command outputs are combinationally muxed from the granted master; ddr3_emif_read=1.
  - Granted waitrequest = !ddr3_emif_ready.
  - On ready: push {id, burst_count} into the tracker, then go to ARB.
- GNT_WR:
  - Command, data and byte-enables muxed from the granted master; ddr3_emif_write = granted mN_write.
  - beats_left is loaded with the burst length at grant.
  - Each cycle with mN_write && ready: decrement beats_left.
  - When beats_left goes 1 to 0, go to ARB.
  - The other master is locked out until then.
  - If the master deasserts write mid-burst, hold the lock (legal Avalon idle beat).
- When not granted: mN_waitrequest=1.
- Ungranted EMIF outputs are 0; addr and data are don't-care but driven 0.
- Read response path:
  - Tracker is a FIFO of {id, len}; resp_cnt counts beats of the head entry.
  - ddr3_emif_read_data fans out to both mN_read_data unregistered.
  - mN_rddata_valid = ddr3_emif_rddata_valid && !trk_empty && head.id==N.
  - On each valid beat, resp_cnt++; at resp_cnt==len-1, pop and clear resp_cnt.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Valid with trk_empty: beat dropped, rsp_err<=1.
- Arithmetic:
  - The tracker counter is log2(TRK_DEPTH)+1 bits.
  - resp_cnt and beats_left are BURST_W bits.
  - Pointers wrap modulo TRK_DEPTH.
- Full tracker: reads are ineligible; writes still arbitrate normally.

Decomposition:
- Shared package ddr3_arb_pkg holds:
  - state encoding ARB/GNT_RD/GNT_WR;
  - master ID constants M_LOADER=0, M_FETCH=1;
  - EMIF width defaults.
- One sub-module: rd_tag_fifo, a synchronous FIFO of {id, len}.
  - Depth TRK_DEPTH; push/pop/full/empty; first-word-fall-through head.

Test Plan:
- Single read: m1 read addr 0x000000, burst 1, ready=1; EMIF returns one beat of 0x55 three cycles later -> emif_read high exactly one cycle; m1_rddata_valid=1 with 0x55; m0_rddata_valid stays 0.
- Write lock: m0 write burst 4 and m1 read asserted in the same cycle -> m0 granted first; 4 write beats forwarded, including one ready=0 stall; m1 waitrequest=1 throughout; m1 read issued immediately after the 4th beat.
- Round-robin: both masters request reads continuously, burst 2 -> grants alternate m0,m1,m0,m1; returned beats route by issue order (2 to m0, then 2 to m1).
- Tracker full: m1 issues 8 reads, burst 1, with no returns -> 9th read held (waitrequest=1) while an m0 write still completes; 9th read issued one cycle after the first return pops the tracker.
- Error/reset: rddata_valid pulse with no outstanding read -> no mN_rddata_valid, rsp_err=1 sticky; assert rst mid-write-burst (beat 2 of 4) -> next cycle state ARB, emif_write=0, rsp_err=0, tracker empty.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the DDR3 EMIF two-master arbiter: FSM encoding,
// master IDs and default EMIF widths.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        GNT_RD = 2'd1,
        GNT_WR = 2'd2
    } arb_state_t;

    localparam logic M_LOADER = 1'b0;
    localparam logic M_FETCH  = 1'b1;

    localparam int DEF_ADDR_W    = 22;
    localparam int DEF_DATA_W    = 256;
    localparam int DEF_BE_W      = DEF_DATA_W / 8;
    localparam int DEF_BURST_W   = 5;
    localparam int DEF_TRK_DEPTH = 8;

endpackage

// File: rtl/rd_tag_fifo.sv
// Read-tag tracker: FIFO of {master id, burst length} for outstanding read
// bursts, with the head entry visible before it is popped.
module rd_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 5
) (
    input  logic             ddr3_emif_clk,
    input  logic             ddr3_emif_rst,
    input  logic             push,
    input  logic             push_id,
    input  logic [LEN_W-1:0] push_len,
    input  logic             pop,
    output logic             head_id,
    output logic [LEN_W-1:0] head_len,
    output logic             full,
    output logic             empty
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             id_mem  [DEPTH];
    logic [LEN_W-1:0] len_mem [DEPTH];
    logic             do_push, do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_id  = id_mem[rd_ptr];
    assign head_len = len_mem[rd_ptr];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ddr3_emif_clk) begin
        if (ddr3_emif_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only read once count says they are valid.
    always_ff @(posedge ddr3_emif_clk) begin
        if (do_push) begin
            id_mem[wr_ptr]  <= push_id;
            len_mem[wr_ptr] <= push_len;
        end
    end

endmodule

// File: rtl/ddr3_emif_arbiter.sv
// Round-robin arbiter sharing one DDR3 EMIF Avalon-MM port between the pattern
// loader and the fetch engine; write bursts hold the grant, read beats are routed by tag.
module ddr3_emif_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BE_W      = DEF_BE_W,
    parameter int BURST_W   = DEF_BURST_W,
    parameter int TRK_DEPTH = DEF_TRK_DEPTH
) (
    input  logic               ddr3_emif_clk,
    input  logic               ddr3_emif_rst,

    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  logic [BURST_W-1:0] m0_burst_count,
    input  logic [DATA_W-1:0]  m0_write_data,
    input  logic [BE_W-1:0]    m0_byte_enable,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_read_data,
    output logic               m0_rddata_valid,

    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic [BURST_W-1:0] m1_burst_count,
    input  logic [DATA_W-1:0]  m1_write_data,
    input  logic [BE_W-1:0]    m1_byte_enable,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_read_data,
    output logic               m1_rddata_valid,

    input  logic               ddr3_emif_ready,
    output logic               ddr3_emif_read,
    output logic               ddr3_emif_write,
    output logic [ADDR_W-1:0]  ddr3_emif_addr,
    output logic [BURST_W-1:0] ddr3_emif_burst_count,
    output logic [DATA_W-1:0]  ddr3_emif_write_data,
    output logic [BE_W-1:0]    ddr3_emif_byte_enable,
    input  logic [DATA_W-1:0]  ddr3_emif_read_data,
    input  logic               ddr3_emif_rddata_valid,

    output logic               rsp_err
);

    arb_state_t         state, state_nx;
    logic               grant, grant_nx;
    logic               last_grant, last_grant_nx;
    logic [BURST_W-1:0] burst_len, burst_len_nx;
    logic [BURST_W-1:0] beats_left, beats_left_nx;
    logic [BURST_W-1:0] resp_cnt;

    logic [1:0]         req_rd, req_wr, elig, wait_vec;
    logic [ADDR_W-1:0]  req_addr [2];
    logic [BURST_W-1:0] req_bc   [2];
    logic [DATA_W-1:0]  req_wd   [2];
    logic [BE_W-1:0]    req_be   [2];
    logic               sel;
    logic [BURST_W-1:0] sel_len;

    logic               trk_push, trk_pop, trk_full, trk_empty, head_id, rsp_valid;
    logic [BURST_W-1:0] head_len;

    assign req_rd      = {m1_read, m0_read};
    assign req_wr      = {m1_write, m0_write};
    assign req_addr[0] = m0_addr;
    assign req_addr[1] = m1_addr;
    assign req_bc[0]   = m0_burst_count;
    assign req_bc[1]   = m1_burst_count;
    assign req_wd[0]   = m0_write_data;
    assign req_wd[1]   = m1_write_data;
    assign req_be[0]   = m0_byte_enable;
    assign req_be[1]   = m1_byte_enable;

    // Reads wait while the tracker is full; writes never need a tag.
    assign elig    = req_wr | (req_rd & {2{~trk_full}});
    assign sel     = (elig == 2'b11) ? ~last_grant : elig[1];
    assign sel_len = (req_bc[sel] == '0) ? BURST_W'(1) : req_bc[sel];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx              = state;
        grant_nx              = grant;
        last_grant_nx         = last_grant;
        burst_len_nx          = burst_len;
        beats_left_nx         = beats_left;
        trk_push              = 1'b0;
        wait_vec              = 2'b11;
        ddr3_emif_read        = 1'b0;
        ddr3_emif_write       = 1'b0;
        ddr3_emif_addr        = '0;
        ddr3_emif_burst_count = '0;
        ddr3_emif_write_data  = '0;
        ddr3_emif_byte_enable = '0;

        case (state)
            ARB: begin
                if (elig != 2'b00) begin
                    grant_nx      = sel;
                    last_grant_nx = sel;
                    burst_len_nx  = sel_len;
                    beats_left_nx = sel_len;
                    state_nx      = req_wr[sel] ? GNT_WR : GNT_RD;
                end
            end
            GNT_RD: begin
                ddr3_emif_read        = 1'b1;
                ddr3_emif_addr        = req_addr[grant];
                ddr3_emif_burst_count = burst_len;
                wait_vec[grant]       = ~ddr3_emif_ready;
                if (ddr3_emif_ready) begin
                    trk_push = 1'b1;
                    state_nx = ARB;
                end
            end
            GNT_WR: begin
                ddr3_emif_write       = req_wr[grant];
                ddr3_emif_addr        = req_addr[grant];
                ddr3_emif_burst_count = burst_len;
                ddr3_emif_write_data  = req_wd[grant];
                ddr3_emif_byte_enable = req_be[grant];
                wait_vec[grant]       = ~ddr3_emif_ready;
                // An idle beat (write low) keeps the lock without consuming a beat.
                if (req_wr[grant] && ddr3_emif_ready) begin
                    beats_left_nx = beats_left - 1'b1;
                    if (beats_left == BURST_W'(1)) state_nx = ARB;
                end
            end
            default: state_nx = ARB;
        endcase
    end

    assign m0_waitrequest = wait_vec[0];
    assign m1_waitrequest = wait_vec[1];

    assign rsp_valid       = ddr3_emif_rddata_valid && !trk_empty;
    assign trk_pop         = rsp_valid && (resp_cnt == head_len - 1'b1);
    assign m0_rddata_valid = rsp_valid && (head_id == M_LOADER);
    assign m1_rddata_valid = rsp_valid && (head_id == M_FETCH);
    assign m0_read_data    = ddr3_emif_read_data;
    assign m1_read_data    = ddr3_emif_read_data;

    always_ff @(posedge ddr3_emif_clk) begin
        if (ddr3_emif_rst) begin
            state      <= ARB;
            grant      <= M_LOADER;
            last_grant <= M_FETCH;
            burst_len  <= BURST_W'(1);
            beats_left <= '0;
            resp_cnt   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            burst_len  <= burst_len_nx;
            beats_left <= beats_left_nx;
            if (trk_pop)        resp_cnt <= '0;
            else if (rsp_valid) resp_cnt <= resp_cnt + 1'b1;
            if (ddr3_emif_rddata_valid && trk_empty) rsp_err <= 1'b1;
        end
    end

    rd_tag_fifo #(
        .DEPTH (TRK_DEPTH),
        .LEN_W (BURST_W)
    ) u_rd_tag_fifo (
        .ddr3_emif_clk (ddr3_emif_clk),
        .ddr3_emif_rst (ddr3_emif_rst),
        .push          (trk_push),
        .push_id       (grant),
        .push_len      (burst_len),
        .pop           (trk_pop),
        .head_id       (head_id),
        .head_len      (head_len),
        .full          (trk_full),
        .empty         (trk_empty)
    );

endmodule

// File: tb/tb_ddr3_emif_arbiter.sv
// Bench for ddr3_emif_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized masters and EMIF.
module tb_ddr3_emif_arbiter;

    localparam int AW = 22;
    localparam int DW = 256;
    localparam int BW = 32;
    localparam int CW = 5;
    localparam int TD = 8;

    localparam int S_IDLE = 0;
    localparam int S_RD   = 1;
    localparam int S_WR   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    rd, wr;
    logic [AW-1:0] ad [2];
    logic [CW-1:0] bc [2];
    logic [DW-1:0] wd [2];
    logic [BW-1:0] be [2];
    logic          wq0, wq1, rv0, rv1;
    logic [DW-1:0] rdat0, rdat1;
    wire  [1:0]    wq = {wq1, wq0};

    logic          ready, e_valid;
    logic [DW-1:0] e_rdata;
    logic          e_read, e_write, rsp_err;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_bc;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;

    ddr3_emif_arbiter dut (
        .ddr3_emif_clk          (clk),
        .ddr3_emif_rst          (rst),
        .m0_read                (rd[0]),
        .m0_write               (wr[0]),
        .m0_addr                (ad[0]),
        .m0_burst_count         (bc[0]),
        .m0_write_data          (wd[0]),
        .m0_byte_enable         (be[0]),
        .m0_waitrequest         (wq0),
        .m0_read_data           (rdat0),
        .m0_rddata_valid        (rv0),
        .m1_read                (rd[1]),
        .m1_write               (wr[1]),
        .m1_addr                (ad[1]),
        .m1_burst_count         (bc[1]),
        .m1_write_data          (wd[1]),
        .m1_byte_enable         (be[1]),
        .m1_waitrequest         (wq1),
        .m1_read_data           (rdat1),
        .m1_rddata_valid        (rv1),
        .ddr3_emif_ready        (ready),
        .ddr3_emif_read         (e_read),
        .ddr3_emif_write        (e_write),
        .ddr3_emif_addr         (e_addr),
        .ddr3_emif_burst_count  (e_bc),
        .ddr3_emif_write_data   (e_wdata),
        .ddr3_emif_byte_enable  (e_be),
        .ddr3_emif_read_data    (e_rdata),
        .ddr3_emif_rddata_valid (e_valid),
        .rsp_err                (rsp_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the port, and the queue of outstanding read bursts.
    typedef struct {
        bit id;
        int len;
    } tag_t;

    tag_t mq[$];
    bit   model_on = 1'b0;
    int   m_state  = S_IDLE;
    bit   m_g      = 1'b0;
    bit   m_last   = 1'b1;
    int   m_len    = 1;
    int   m_left   = 0;
    int   m_rcnt   = 0;
    bit   m_err    = 1'b0;

    bit            x_busy, x_full;
    bit [1:0]      x_wq, x_rv, x_el;
    logic [AW-1:0] x_addr;
    logic [CW-1:0] x_bc;
    logic [DW-1:0] x_wd;
    logic [BW-1:0] x_be;

    always @(negedge clk) begin
        if (model_on) begin
            x_busy = (m_state != S_IDLE);
            x_addr = x_busy ? ad[m_g] : '0;
            x_bc   = x_busy ? CW'(m_len) : '0;
            x_wd   = (m_state == S_WR) ? wd[m_g] : '0;
            x_be   = (m_state == S_WR) ? be[m_g] : '0;
            for (int k = 0; k < 2; k++) begin
                x_wq[k] = !(x_busy && (int'(m_g) == k) && ready);
                x_rv[k] = e_valid && (mq.size() != 0) && (int'(mq[0].id) == k);
            end
            check("emif_read",  DW'(e_read),  DW'(m_state == S_RD));
            check("emif_write", DW'(e_write), DW'((m_state == S_WR) && wr[m_g]));
            check("emif_addr",  DW'(e_addr),  DW'(x_addr));
            check("emif_burst", DW'(e_bc),    DW'(x_bc));
            check("emif_wdata", e_wdata,      x_wd);
            check("emif_be",    DW'(e_be),    DW'(x_be));
            check("m0_wait",    DW'(wq0),     DW'(x_wq[0]));
            check("m1_wait",    DW'(wq1),     DW'(x_wq[1]));
            check("m0_rvalid",  DW'(rv0),     DW'(x_rv[0]));
            check("m1_rvalid",  DW'(rv1),     DW'(x_rv[1]));
            check("m0_rdata",   rdat0,        e_rdata);
            check("m1_rdata",   rdat1,        e_rdata);
            check("rsp_err",    DW'(rsp_err), DW'(m_err));

            if (rst) begin
                mq.delete();
                m_state = S_IDLE;
                m_last  = 1'b1;
                m_rcnt  = 0;
                m_err   = 1'b0;
            end else begin
                x_full = (mq.size() == TD);
                if (e_valid) begin
                    if (mq.size() == 0) m_err = 1'b1;
                    else begin
                        m_rcnt++;
                        if (m_rcnt == mq[0].len) begin
                            void'(mq.pop_front());
                            m_rcnt = 0;
                        end
                    end
                end
                case (m_state)
                    S_IDLE: begin
                        for (int k = 0; k < 2; k++) x_el[k] = wr[k] || (rd[k] && !x_full);
                        if (x_el != 2'b00) begin
                            m_g     = (x_el == 2'b11) ? !m_last : x_el[1];
                            m_last  = m_g;
                            m_len   = (bc[m_g] == '0) ? 1 : int'(bc[m_g]);
                            m_left  = m_len;
                            m_state = wr[m_g] ? S_WR : S_RD;
                        end
                    end
                    S_RD: if (ready) begin
                        mq.push_back('{m_g, m_len});
                        m_state = S_IDLE;
                    end
                    default: if (wr[m_g] && ready) begin
                        m_left--;
                        if (m_left == 0) m_state = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Randomized Avalon masters and EMIF responder.
    int ph [2];
    int len [2];
    int sent [2];
    int ret_pend = 0;

    task automatic rand_cycle(input bit allow_new);
        bit acc [2];
        int r;
        @(negedge clk);
        for (int k = 0; k < 2; k++) acc[k] = (rd[k] || wr[k]) && !wq[k];
        if (e_read && ready) ret_pend += int'(e_bc);
        step();
        for (int k = 0; k < 2; k++) begin
            if (ph[k] == 1 && acc[k]) begin
                ph[k] = 0;
                rd[k] = 1'b0;
            end else if (ph[k] == 2) begin
                if (acc[k]) begin
                    sent[k]++;
                    wd[k] = {8{$urandom}};
                    be[k] = BW'($urandom);
                end
                if (sent[k] == len[k]) begin
                    ph[k] = 0;
                    wr[k] = 1'b0;
                end else if (!wr[k] || acc[k]) begin
                    wr[k] = ($urandom % 4) != 0;
                end
            end
            if (ph[k] == 0 && allow_new) begin
                r = int'($urandom % 6);
                if (r < 2) begin
                    ad[k]   = AW'($urandom);
                    bc[k]   = CW'($urandom_range(0, 4));
                    len[k]  = (bc[k] == '0) ? 1 : int'(bc[k]);
                    sent[k] = 0;
                    if (r == 0) begin
                        ph[k] = 1;
                        rd[k] = 1'b1;
                    end else begin
                        ph[k] = 2;
                        wr[k] = 1'b1;
                        wd[k] = {8{$urandom}};
                        be[k] = BW'($urandom);
                    end
                end
            end
        end
        ready   = ($urandom % 4) != 0;
        e_valid = (ret_pend > 0) && (($urandom % 2) != 0);
        if (e_valid) ret_pend--;
        e_rdata = {8{$urandom}};
    endtask

    int  n, rd_cyc, last_beat, ord [4];
    bit  acc0, acc1, ok;

    initial begin
        rst = 1'b1; rd = '0; wr = '0; ready = 1'b1; e_valid = 1'b0; e_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            ad[k] = '0; bc[k] = '0; wd[k] = '0; be[k] = '0;
            ph[k] = 0; len[k] = 1; sent[k] = 0;
        end
        step();
        model_on = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_emif_read",  DW'(e_read),  DW'(0));
        check("rst_emif_write", DW'(e_write), DW'(0));
        check("rst_m0_wait",    DW'(wq0),     DW'(1));
        check("rst_m1_wait",    DW'(wq1),     DW'(1));
        check("rst_rsp_err",    DW'(rsp_err), DW'(0));
        step();

        // Single read from m1.
        rd[1] = 1'b1; ad[1] = '0; bc[1] = CW'(1);
        rd_cyc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (e_read) rd_cyc++;
            acc1 = rd[1] && !wq1;
            step();
            if (acc1) rd[1] = 1'b0;
        end
        check("single_rd_cycles", DW'(rd_cyc), DW'(1));
        e_valid = 1'b1; e_rdata = DW'(8'h55);
        @(negedge clk);
        check("single_m1_valid", DW'(rv1), DW'(1));
        check("single_m1_data",  rdat1,    DW'(8'h55));
        check("single_m0_valid", DW'(rv0), DW'(0));
        step();
        e_valid = 1'b0;

        // Write burst lock against a simultaneous m1 read.
        wr[0] = 1'b1; ad[0] = AW'(22'h100); bc[0] = CW'(4); wd[0] = DW'(1); be[0] = '1;
        rd[1] = 1'b1; ad[1] = AW'(22'h200); bc[1] = CW'(1);
        n = 0; last_beat = -1; rd_cyc = -1; ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ready = (c != 3);
            @(negedge clk);
            if (wr[0] && !wq0) begin
                check("lock_wdata", e_wdata, DW'(n + 1));
                n++;
                if (n == 4) last_beat = c;
            end
            if (n < 4 && !wq1) ok = 1'b0;
            if (e_read && rd_cyc < 0) rd_cyc = c;
            acc1 = rd[1] && !wq1;
            step();
            if (n == 4) wr[0] = 1'b0;
            else        wd[0] = DW'(n + 1);
            if (acc1) rd[1] = 1'b0;
        end
        ready = 1'b1;
        check("lock_beats",     DW'(n),      DW'(4));
        check("lock_m1_wait",   DW'(ok),     DW'(1));
        check("lock_rd_follow", DW'(rd_cyc), DW'(last_beat + 2));
        e_valid = 1'b1; e_rdata = DW'(8'hAA);
        @(negedge clk);
        check("lock_m1_ret", DW'(rv1), DW'(1));
        step();
        e_valid = 1'b0;

        // Round-robin with both masters reading continuously.
        rd = 2'b11; bc[0] = CW'(2); bc[1] = CW'(2);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            acc0 = rd[0] && !wq0;
            acc1 = rd[1] && !wq1;
            step();
            if (acc0 && n < 4) begin ord[n] = 0; n++; end
            if (acc1 && n < 4) begin ord[n] = 1; n++; end
            if (n >= 4) rd = 2'b00;
        end
        rd = 2'b00;
        check("rr_grants", DW'(n), DW'(4));
        check("rr_ord0", DW'(ord[0]), DW'(0));
        check("rr_ord1", DW'(ord[1]), DW'(1));
        check("rr_ord2", DW'(ord[2]), DW'(0));
        check("rr_ord3", DW'(ord[3]), DW'(1));
        for (int b = 0; b < 8; b++) begin
            e_valid = 1'b1; e_rdata = DW'(b);
            @(negedge clk);
            check("rr_route_m0", DW'(rv0), DW'(((b / 2) % 2) == 0));
            check("rr_route_m1", DW'(rv1), DW'(((b / 2) % 2) == 1));
            step();
        end
        e_valid = 1'b0;

        // Tracker full: eight outstanding reads, ninth held while a write proceeds.
        rd[1] = 1'b1; ad[1] = AW'(22'h300); bc[1] = CW'(1);
        n = 0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            @(negedge clk);
            acc1 = rd[1] && !wq1;
            step();
            if (acc1) begin n++; ad[1] = ad[1] + 1'b1; end
        end
        check("full_issued", DW'(n), DW'(8));
        wr[0] = 1'b1; ad[0] = AW'(22'h400); bc[0] = CW'(2); wd[0] = DW'(16'hBEEF);
        n = 0; ok = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!wq1) ok = 1'b0;
            acc0 = wr[0] && !wq0;
            step();
            if (acc0) n++;
            if (n == 2) wr[0] = 1'b0;
        end
        check("full_wr_beats", DW'(n),  DW'(2));
        check("full_m1_held",  DW'(ok), DW'(1));
        e_valid = 1'b1;
        @(negedge clk);
        check("full_pop_valid", DW'(rv1), DW'(1));
        step();
        e_valid = 1'b0;
        @(negedge clk);
        check("full_arb_read", DW'(e_read), DW'(0));
        step();
        @(negedge clk);
        check("full_9th_read", DW'(e_read), DW'(1));
        check("full_9th_wait", DW'(wq1),    DW'(0));
        step();
        rd[1] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            e_valid = 1'b1;
            @(negedge clk);
            check("drain_m1", DW'(rv1), DW'(1));
            step();
        end
        e_valid = 1'b0;

        // Spurious response, then reset in the middle of a write burst.
        e_valid = 1'b1;
        @(negedge clk);
        check("spur_m0", DW'(rv0), DW'(0));
        check("spur_m1", DW'(rv1), DW'(0));
        step();
        e_valid = 1'b0;
        @(negedge clk);
        check("err_set", DW'(rsp_err), DW'(1));
        step();
        step();
        @(negedge clk);
        check("err_sticky", DW'(rsp_err), DW'(1));
        step();
        rd[1] = 1'b1; bc[1] = CW'(1);
        for (int c = 0; c < 10 && rd[1]; c++) begin
            @(negedge clk);
            acc1 = rd[1] && !wq1;
            step();
            if (acc1) rd[1] = 1'b0;
        end
        wr[0] = 1'b1; bc[0] = CW'(4);
        n = 0;
        for (int c = 0; c < 20 && n < 1; c++) begin
            @(negedge clk);
            acc0 = wr[0] && !wq0;
            step();
            if (acc0) n++;
        end
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0; wr[0] = 1'b0; rd[1] = 1'b0;
        @(negedge clk);
        check("mid_rst_write", DW'(e_write), DW'(0));
        check("mid_rst_m0w",   DW'(wq0),     DW'(1));
        check("mid_rst_m1w",   DW'(wq1),     DW'(1));
        check("mid_rst_err",   DW'(rsp_err), DW'(0));
        step();
        e_valid = 1'b1;
        @(negedge clk);
        check("stale_beat_m1", DW'(rv1), DW'(0));
        step();
        e_valid = 1'b0;
        @(negedge clk);
        check("stale_beat_err", DW'(rsp_err), DW'(1));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Randomized traffic, then drain.
        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
        for (int c = 0; c < 600 && (ph[0] != 0 || ph[1] != 0 || ret_pend != 0); c++) rand_cycle(1'b0);
        check("rand_drained", DW'(ph[0] == 0 && ph[1] == 0 && ret_pend == 0), DW'(1));
        e_valid = 1'b0;
        @(negedge clk);
        check("rand_no_err", DW'(rsp_err), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
